led_flasher: RTL and testbench
==============================

LED_FLASHER -- requirements
Module: led_flasher

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter ACTIVE, default 1, pin level meaning "LED on" (1 = active-high, 0 = active-low).
REQ-003 The block SHALL have parameter ON_MS, default 100, on-time per flash in milliseconds (legal range 1..1000).
REQ-004 The block SHALL have parameter OFF_MS, default 100, off-time per flash in milliseconds (legal range 1..1000).
REQ-005 The block SHALL have port clk, input, 1 bit, system clock; every register updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit, one-cycle request to begin a flash sequence.
REQ-008 The block SHALL have port count, input, 4 bits, number of flashes; the block samples it only in the cycle start is accepted.
REQ-009 The block SHALL have port pin, output, 1 bit, registered LED drive.
REQ-010 The block SHALL have port busy, output, 1 bit, high while a sequence is in progress.
REQ-011 The block SHALL have port done, output, 1 bit, one-cycle pulse marking the end of a sequence.

Function
REQ-012 The block SHALL derive ON_CYCLES = (CLK_FREQ/1000)*ON_MS and OFF_CYCLES = (CLK_FREQ/1000)*OFF_MS as constants.
- Width: 32-bit unsigned.
- Arithmetic: integer, truncating.
REQ-013 The block SHALL implement three states: IDLE, ON and OFF.
REQ-014 In IDLE the block SHALL hold pin = ~ACTIVE and busy = 0.
REQ-015 In IDLE, start=1 with count!=0 SHALL cause the following on the next edge:
- latch count into a 4-bit remaining register;
- load the 32-bit timer with ON_CYCLES;
- enter ON.
REQ-016 In IDLE, start=1 with count==0 SHALL pulse done for exactly one cycle on the next edge and remain in IDLE; pin does not change.
REQ-017 In ON the block SHALL drive pin = ACTIVE and busy = 1.
- Duration: exactly ON_CYCLES clock cycles.
- Exit: enter OFF with the timer loaded with OFF_CYCLES.
REQ-018 In OFF the block SHALL drive pin = ~ACTIVE and busy = 1 for exactly OFF_CYCLES cycles, then decrement remaining.
- remaining now nonzero: re-enter ON.
- remaining now zero: enter IDLE.
REQ-019 On the OFF->IDLE transition the block SHALL assert done for exactly one cycle, coincident with the first IDLE cycle (busy = 0 in that cycle).
REQ-020 A sequence of N flashes SHALL keep busy high for exactly N*(ON_CYCLES+OFF_CYCLES) consecutive cycles.
REQ-021 While busy=1, start SHALL be ignored and the count input SHALL have no effect.
REQ-022 In the done cycle, start=1 SHALL be accepted exactly as in IDLE.
REQ-023 pin, busy and done SHALL be driven directly from flip-flops, with no combinational path from any input.
REQ-024 The timer SHALL never wrap; every state change SHALL occur when the timer reaches 1.

Reset
REQ-025 Asserting reset SHALL, immediately and without waiting for clk, set:
- state = IDLE;
- pin = ~ACTIVE, busy = 0, done = 0;
- timer = 0, remaining = 0.
REQ-026 Reset asserted mid-sequence SHALL abort the sequence without producing a done pulse.
REQ-027 After reset deasserts, the first start SHALL be accepted on the first clk edge.

Structure
REQ-028 A shared package led_pkg SHALL hold:
- the state enum (IDLE, ON, OFF);
- the default SYSCLOCK_FREQ constant, 100000000.
REQ-029 The block SHALL instantiate one sub-module, down_timer.
- Behaviour: loadable 32-bit down-counter with async reset.
- Output: a one-cycle expire flag when the count reaches 1.
- The FSM stays in led_flasher.

Verification (bench uses CLK_FREQ=2000, ON_MS=2, OFF_MS=1, so ON_CYCLES=4 and OFF_CYCLES=2)
REQ-030 start=1 with count=3, ACTIVE=1 -> pin pattern 1111 00 1111 00 1111 00; busy high 18 cycles; done high in cycle 19 only.
REQ-031 start=1 with count=0 -> done high one cycle later; busy and pin stay 0.
REQ-032 start pulsed again at cycle 5 of a count=2 sequence -> ignored; total busy is exactly 12 cycles.
REQ-033 reset asserted at cycle 7 of a count=2 sequence -> pin=0 and busy=0 immediately (asynchronously); no done pulse follows.
REQ-034 ACTIVE=0 with count=1 -> pin idles 1, reads 0000 then 11, done at cycle 7.
REQ-035 start=1 with count=1 during the done cycle of a previous sequence -> new sequence starts on the next edge with no idle gap.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED flasher.
//   led_state_t   : flasher FSM states (IDLE, ON, OFF)
//   SYSCLOCK_FREQ : default system clock frequency in Hz
//   ms_to_cycles  : milliseconds -> clock cycles at a given frequency
package led_pkg;

  localparam int unsigned SYSCLOCK_FREQ = 100000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } led_state_t;

  // Truncating integer conversion; the kHz rate is formed first so the
  // product stays well inside 32 bits for the legal 1..1000 ms range.
  function automatic logic [31:0] ms_to_cycles(input int unsigned freq,
                                               input int unsigned ms);
    return 32'((freq / 1000) * ms);
  endfunction

endpackage

// File: rtl/down_timer.sv
// Loadable down-counter with asynchronous reset.
//   i_clk    : clock
//   i_rst    : asynchronous active-high reset, clears the count
//   i_load   : load i_value into the counter on the next edge
//   i_value  : value to load
//   o_expire : high for the single cycle in which the count equals 1
module down_timer #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  // Counting stops at zero so the timer can never wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expire = (r_count == W'(1));

endmodule

// File: rtl/led_flasher.sv
// LED flasher: on start, flashes the LED `count` times (ON_MS on, OFF_MS
// off each), then pulses done for one cycle.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   start : one-cycle request to begin a sequence (ignored while busy)
//   count : number of flashes, sampled only when start is accepted
//   pin   : registered LED drive, ACTIVE level means "LED on"
//   busy  : high while a sequence is running
//   done  : one-cycle pulse in the first idle cycle after a sequence,
//           or one cycle after a start with count == 0
module led_flasher
  import led_pkg::*;
#(
  parameter int unsigned CLK_FREQ = SYSCLOCK_FREQ,
  parameter logic        ACTIVE   = 1'b1,
  parameter int unsigned ON_MS    = 100,
  parameter int unsigned OFF_MS   = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] count,
  output logic       pin,
  output logic       busy,
  output logic       done
);

  localparam logic [31:0] ON_CYCLES  = ms_to_cycles(CLK_FREQ, ON_MS);
  localparam logic [31:0] OFF_CYCLES = ms_to_cycles(CLK_FREQ, OFF_MS);

  led_state_t  r_state;
  logic [3:0]  r_remaining;
  logic        r_pin;
  logic        r_busy;
  logic        r_done;

  logic        w_accept;
  logic        w_expire;
  logic        w_load;
  logic [31:0] w_load_val;
  logic [3:0]  w_rem_dec;

  // The done cycle is an IDLE cycle, so back-to-back starts need no gap.
  assign w_accept  = (r_state == IDLE) && start && (count != 4'd0);
  assign w_rem_dec = r_remaining - 4'd1;

  // Timer reload points: entering ON (from IDLE or OFF) and entering OFF.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = ON_CYCLES;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load     = 1'b1;
          w_load_val = ON_CYCLES;
        end
      end
      ON: begin
        if (w_expire) begin
          w_load     = 1'b1;
          w_load_val = OFF_CYCLES;
        end
      end
      OFF: begin
        if (w_expire && (w_rem_dec != 4'd0)) begin
          w_load     = 1'b1;
          w_load_val = ON_CYCLES;
        end
      end
      default: begin
        w_load     = 1'b0;
        w_load_val = ON_CYCLES;
      end
    endcase
  end

  down_timer #(
    .W(32)
  ) u_timer (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_load   (w_load),
    .i_value  (w_load_val),
    .o_expire (w_expire)
  );

  // Outputs are registered alongside the state so each one changes on the
  // same edge as the state it reflects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_remaining <= 4'd0;
      r_pin       <= ~ACTIVE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (count != 4'd0) begin
              r_remaining <= count;
              r_state     <= ON;
              r_pin       <= ACTIVE;
              r_busy      <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ON: begin
          if (w_expire) begin
            r_state <= OFF;
            r_pin   <= ~ACTIVE;
          end
        end
        OFF: begin
          if (w_expire) begin
            r_remaining <= w_rem_dec;
            if (w_rem_dec != 4'd0) begin
              r_state <= ON;
              r_pin   <= ACTIVE;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_pin   <= ~ACTIVE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pin  = r_pin;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_led_flasher.sv
// Bench for led_flasher: two instances (active-high and active-low pin)
// share one stimulus. A sequence-level model predicts busy/pin/done and is
// compared every cycle; directed scenarios add literal expectations.
module tb_led_flasher;

  localparam int ON_C  = 4;   // (2000/1000)*2
  localparam int OFF_C = 2;   // (2000/1000)*1
  localparam int PER_C = ON_C + OFF_C;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] count;
  logic       pin_hi, busy_hi, done_hi;
  logic       pin_lo, busy_lo, done_lo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_flasher #(.CLK_FREQ(2000), .ACTIVE(1'b1), .ON_MS(2), .OFF_MS(1)) u_hi (
    .clk(clk), .reset(reset), .start(start), .count(count),
    .pin(pin_hi), .busy(busy_hi), .done(done_hi)
  );

  led_flasher #(.CLK_FREQ(2000), .ACTIVE(1'b0), .ON_MS(2), .OFF_MS(1)) u_lo (
    .clk(clk), .reset(reset), .start(start), .count(count),
    .pin(pin_lo), .busy(busy_lo), .done(done_lo)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sequence model: a run of N flashes is N*PER_C busy cycles; inside it the
  // LED is on for the first ON_C cycles of every PER_C-cycle period.
  int m_left = 0;
  int m_pos  = 0;
  bit m_done = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left <= 0;
      m_pos  <= 0;
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_pos  <= m_pos + 1;
      m_done <= (m_left == 1);
    end else begin
      m_pos <= 0;
      if (start && count != 4'd0) begin
        m_left <= int'(count) * PER_C;
        m_done <= 1'b0;
      end else begin
        m_done <= start;
      end
    end
  end

  always @(negedge clk) begin
    bit exp_busy;
    bit exp_on;
    exp_busy = (m_left > 0);
    exp_on   = exp_busy && ((m_pos % PER_C) < ON_C);
    check("cyc_busy_hi", 32'(busy_hi), 32'(exp_busy));
    check("cyc_busy_lo", 32'(busy_lo), 32'(exp_busy));
    check("cyc_pin_hi",  32'(pin_hi),  32'(exp_on));
    check("cyc_pin_lo",  32'(pin_lo),  32'(!exp_on));
    check("cyc_done_hi", 32'(done_hi), 32'(m_done));
    check("cyc_done_lo", 32'(done_lo), 32'(m_done));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [17:0] pat18;
    logic [5:0]  pat6;
    int bcnt;
    int dcnt;

    reset = 1'b0;
    start = 1'b0;
    count = 4'd0;
    #1 reset = 1'b1;
    #1;
    check("rst_pin_hi", 32'(pin_hi), 32'd0);
    check("rst_pin_lo", 32'(pin_lo), 32'd1);
    check("rst_busy",   32'(busy_hi), 32'd0);
    check("rst_done",   32'(done_hi), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // count=3: 1111 00 repeated three times, done in cycle 19
    start = 1'b1; count = 4'd3;
    tick();
    start = 1'b0; count = 4'd0;
    bcnt = 0; dcnt = 0;
    for (int i = 0; i < 18; i++) begin
      pat18[17-i] = pin_hi;
      bcnt += int'(busy_hi);
      dcnt += int'(done_hi);
      tick();
    end
    check("c3_pattern", 32'(pat18), 32'(18'b111100111100111100));
    check("c3_busy_len", 32'(bcnt), 32'd18);
    check("c3_no_early_done", 32'(dcnt), 32'd0);
    check("c3_done19", 32'(done_hi), 32'd1);
    check("c3_idle_busy", 32'(busy_hi), 32'd0);
    tick();
    check("c3_done_one_cycle", 32'(done_hi), 32'd0);
    tick();

    // count=0: done one cycle later, nothing else moves
    start = 1'b1; count = 4'd0;
    tick();
    start = 1'b0;
    check("c0_done", 32'(done_hi), 32'd1);
    check("c0_busy", 32'(busy_hi), 32'd0);
    check("c0_pin",  32'(pin_hi), 32'd0);
    tick();
    check("c0_done_clear", 32'(done_hi), 32'd0);
    tick();

    // count=2 with a second start (and new count) at cycle 5: ignored
    start = 1'b1; count = 4'd2;
    tick();
    start = 1'b0;
    bcnt = 0; dcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      bcnt += int'(busy_hi);
      dcnt += int'(done_hi);
      if (i == 5) begin
        start = 1'b1; count = 4'hF;
      end else begin
        start = 1'b0; count = 4'd0;
      end
      tick();
    end
    check("ign_busy_len", 32'(bcnt), 32'd12);
    check("ign_done_cnt", 32'(dcnt), 32'd1);

    // reset at cycle 7 of count=2: immediate idle, no done afterwards
    start = 1'b1; count = 4'd2;
    tick();
    start = 1'b0; count = 4'd0;
    repeat (6) tick();
    check("ab_busy_before", 32'(busy_hi), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ab_pin_hi_async", 32'(pin_hi), 32'd0);
    check("ab_pin_lo_async", 32'(pin_lo), 32'd1);
    check("ab_busy_async",   32'(busy_hi), 32'd0);
    tick();
    reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 14; i++) begin
      dcnt += int'(done_hi) + int'(busy_hi);
      tick();
    end
    check("ab_no_done", 32'(dcnt), 32'd0);

    // start together with reset release: accepted on the first edge
    reset = 1'b1;
    tick();
    reset = 1'b0; start = 1'b1; count = 4'd1;
    tick();
    start = 1'b0; count = 4'd0;
    check("rel_first_edge", 32'(busy_hi), 32'd1);
    repeat (8) tick();

    // ACTIVE=0, count=1: idles 1, reads 0000 11, done at cycle 7,
    // with a new start during that done cycle
    check("lo_idle_pin", 32'(pin_lo), 32'd1);
    start = 1'b1; count = 4'd1;
    tick();
    start = 1'b0; count = 4'd0;
    for (int i = 0; i < 6; i++) begin
      pat6[5-i] = pin_lo;
      tick();
    end
    check("lo_pattern", 32'(pat6), 32'(6'b000011));
    check("lo_done7", 32'(done_lo), 32'd1);
    start = 1'b1; count = 4'd1;
    tick();
    start = 1'b0; count = 4'd0;
    check("b2b_busy", 32'(busy_hi), 32'd1);
    check("b2b_pin",  32'(pin_hi), 32'd1);
    check("b2b_done_clear", 32'(done_hi), 32'd0);
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
